multi_mode_timer: RTL and testbench

Parametrised successor to the watch/stopwatch top. It integrates three independently running time bases behind one display bus:
- a settable wall clock
- a stopwatch with a lap-capture buffer
- a countdown timer with an alarm

A mode input steers buttons and selects the display. All three counters run whenever their own state says so, regardless of which mode is displayed. The time_data output feeds the existing FND/UART formatting path unchanged.

---
 rtl/multi_mode_timer.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_multi_mode_timer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_timer.sv
// multi_mode_timer: wall clock, stopwatch with lap buffer and countdown timer
// sharing one display bus. All three time bases run continuously according to
// their own state; mode_i only steers buttons and selects what is displayed.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous reset, active low
//   mode_i       00 watch, 01 stopwatch, 10 countdown, 11 lap view
//   btn_start_i  run/stop toggle, alarm acknowledge (1-cycle pulse)
//   btn_clear_i  stopwatch clear, countdown reload, alarm acknowledge
//   btn_lap_i    lap capture (stopwatch) / read pointer advance (lap view)
//   set_sel_i    adjust field: 00 sec, 01 min, 10 hour, 11 none
//   btn_up_i     selected field +1 (btn_up_i wins if both pulse together)
//   btn_down_i   selected field -1
//   time_data_o  {hour[4:0], min[5:0], sec[5:0], msec[6:0]} of displayed source
//   lap_count_o  valid lap entries, saturating at LAP_DEPTH
//   running_o    displayed source is counting
//   alarm_o      countdown expired, held until acknowledged
//
// Stopwatch FSM
//   state    | meaning
//   SW_IDLE  | cleared, not counting
//   SW_RUN   | counting on every tick, laps captured
//   SW_STOP  | holding value, clear allowed
//
// Countdown FSM
//   state    | meaning
//   CD_IDLE  | preset editable, count mirrors preset
//   CD_RUN   | decrementing on every tick
//   CD_PAUSE | holding value
//   CD_ALARM | reached zero, alarm asserted until acknowledged
module multi_mode_timer #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int HOUR_MAX  = 24,
    parameter int LAP_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [1:0]                     mode_i,
    input  logic                           btn_start_i,
    input  logic                           btn_clear_i,
    input  logic                           btn_lap_i,
    input  logic [1:0]                     set_sel_i,
    input  logic                           btn_up_i,
    input  logic                           btn_down_i,
    output logic [23:0]                    time_data_o,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count_o,
    output logic                           running_o,
    output logic                           alarm_o
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(LAP_DEPTH);
    localparam int CW  = $clog2(LAP_DEPTH + 1);

    localparam logic [DW-1:0] DIV_TOP = DW'(DIV - 1);
    localparam logic [6:0]    MS_TOP  = 7'(TICK_HZ - 1);
    localparam logic [5:0]    SM_TOP  = 6'd59;
    localparam logic [4:0]    HR_TOP  = 5'(HOUR_MAX - 1);
    localparam logic [PW-1:0] PTR_TOP = PW'(LAP_DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LAP_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] M_WATCH = 2'b00;
    localparam logic [1:0] M_SW    = 2'b01;
    localparam logic [1:0] M_CD    = 2'b10;
    localparam logic [1:0] M_LAP   = 2'b11;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] mn;
        logic [5:0] sc;
        logic [6:0] ms;
    } time_t;

    typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_STOP} sw_state_t;
    typedef enum logic [1:0] {CD_IDLE, CD_RUN, CD_PAUSE, CD_ALARM} cd_state_t;

    function automatic time_t t_inc(input time_t t);
        time_t r;
        r = t;
        if (t.ms != MS_TOP) r.ms = t.ms + 7'd1;
        else begin
            r.ms = '0;
            if (t.sc != SM_TOP) r.sc = t.sc + 6'd1;
            else begin
                r.sc = '0;
                if (t.mn != SM_TOP) r.mn = t.mn + 6'd1;
                else begin
                    r.mn = '0;
                    r.hr = (t.hr == HR_TOP) ? 5'd0 : t.hr + 5'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic time_t t_dec(input time_t t);
        time_t r;
        r = t;
        if (t.ms != 7'd0) r.ms = t.ms - 7'd1;
        else begin
            r.ms = MS_TOP;
            if (t.sc != 6'd0) r.sc = t.sc - 6'd1;
            else begin
                r.sc = SM_TOP;
                if (t.mn != 6'd0) r.mn = t.mn - 6'd1;
                else begin
                    r.mn = SM_TOP;
                    r.hr = (t.hr == 5'd0) ? HR_TOP : t.hr - 5'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [5:0] wrap60(input logic [5:0] v, input logic up);
        if (up) return (v == SM_TOP) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? SM_TOP : v - 6'd1;
    endfunction

    // Manual adjust: wraps inside the selected field, never carries.
    function automatic time_t t_adj(input time_t t, input logic [1:0] sel, input logic up);
        time_t r;
        r = t;
        case (sel)
            2'b00:   r.sc = wrap60(t.sc, up);
            2'b01:   r.mn = wrap60(t.mn, up);
            2'b10:   r.hr = up ? ((t.hr == HR_TOP) ? 5'd0 : t.hr + 5'd1)
                              : ((t.hr == 5'd0) ? HR_TOP : t.hr - 5'd1);
            default: r = t;
        endcase
        return r;
    endfunction

    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;
    time_t         watch_q, watch_d;
    time_t         sw_q, sw_d;
    time_t         cd_q, cd_d;
    time_t         preset_q, preset_d;
    time_t         cd_dec;
    sw_state_t     sw_state_q, sw_state_d;
    cd_state_t     cd_state_q, cd_state_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    time_t         lap_buf_q [LAP_DEPTH];
    logic          lap_we;
    logic          adj_req;
    logic          in_sw, in_cd;

    always_comb begin
        div_d      = (div_q == DIV_TOP) ? '0 : div_q + DW'(1);
        tick_d     = (div_q == DIV_TOP);
        watch_d    = watch_q;
        sw_d       = sw_q;
        cd_d       = cd_q;
        preset_d   = preset_q;
        sw_state_d = sw_state_q;
        cd_state_d = cd_state_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        lcnt_d     = lcnt_q;
        lap_we     = 1'b0;
        adj_req    = btn_up_i | btn_down_i;
        in_sw      = (mode_i == M_SW);
        in_cd      = (mode_i == M_CD);
        cd_dec     = t_dec(cd_q);

        // An adjust on the same edge as a tick swallows that tick.
        if ((mode_i == M_WATCH) && adj_req && (set_sel_i != 2'b11))
            watch_d = t_adj(watch_q, set_sel_i, btn_up_i);
        else if (tick_q)
            watch_d = t_inc(watch_q);

        if ((sw_state_q == SW_RUN) && tick_q) sw_d = t_inc(sw_q);
        if (in_sw) begin
            case (sw_state_q)
                SW_IDLE: if (btn_start_i) sw_state_d = SW_RUN;
                SW_RUN: begin
                    if (btn_start_i) sw_state_d = SW_STOP;
                    if (btn_lap_i) begin
                        lap_we = 1'b1;
                        wr_d   = (wr_q == PTR_TOP) ? '0 : wr_q + PTR_ONE;
                        // Full buffer: the oldest entry is overwritten, so the
                        // read pointer follows it to stay on the oldest.
                        if (lcnt_q == CNT_MAX)
                            rd_d = (rd_q == PTR_TOP) ? '0 : rd_q + PTR_ONE;
                        else
                            lcnt_d = lcnt_q + CNT_ONE;
                    end
                end
                SW_STOP: begin
                    if (btn_start_i) sw_state_d = SW_RUN;
                    else if (btn_clear_i) begin
                        sw_state_d = SW_IDLE;
                        sw_d       = '0;
                        lcnt_d     = '0;
                        wr_d       = '0;
                        rd_d       = '0;
                    end
                end
                default: sw_state_d = SW_IDLE;
            endcase
        end

        if ((mode_i == M_LAP) && btn_lap_i && (lcnt_q != '0))
            rd_d = (CW'(rd_q) == lcnt_q - CNT_ONE) ? '0 : rd_q + PTR_ONE;

        case (cd_state_q)
            CD_IDLE: begin
                if (in_cd && adj_req) preset_d = t_adj(preset_q, set_sel_i, btn_up_i);
                cd_d = preset_d;
                if (in_cd && btn_start_i && (preset_q != '0)) cd_state_d = CD_RUN;
            end
            CD_RUN: begin
                if (in_cd && btn_clear_i) begin
                    cd_state_d = CD_IDLE;
                    cd_d       = preset_q;
                end else begin
                    if (tick_q) begin
                        cd_d = cd_dec;
                        if (cd_dec == '0) cd_state_d = CD_ALARM;
                    end
                    if (in_cd && btn_start_i && (cd_state_d != CD_ALARM)) cd_state_d = CD_PAUSE;
                end
            end
            CD_PAUSE: begin
                if (in_cd && btn_start_i) cd_state_d = CD_RUN;
                else if (in_cd && btn_clear_i) begin
                    cd_state_d = CD_IDLE;
                    cd_d       = preset_q;
                end
            end
            CD_ALARM: begin
                cd_d = '0;
                if (in_cd && (btn_start_i || btn_clear_i)) begin
                    cd_state_d = CD_IDLE;
                    cd_d       = preset_q;
                end
            end
            default: cd_state_d = CD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            div_q      <= '0;
            tick_q     <= 1'b0;
            watch_q    <= '0;
            sw_q       <= '0;
            cd_q       <= '0;
            preset_q   <= '0;
            sw_state_q <= SW_IDLE;
            cd_state_q <= CD_IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            lcnt_q     <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) lap_buf_q[i] <= '0;
        end else begin
            div_q      <= div_d;
            tick_q     <= tick_d;
            watch_q    <= watch_d;
            sw_q       <= sw_d;
            cd_q       <= cd_d;
            preset_q   <= preset_d;
            sw_state_q <= sw_state_d;
            cd_state_q <= cd_state_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            lcnt_q     <= lcnt_d;
            if (lap_we) lap_buf_q[wr_q] <= sw_q;
        end
    end

    always_comb begin
        time_data_o = '0;
        running_o   = 1'b0;
        case (mode_i)
            M_WATCH: begin
                time_data_o = watch_q;
                running_o   = 1'b1;
            end
            M_SW: begin
                time_data_o = sw_q;
                running_o   = (sw_state_q == SW_RUN);
            end
            M_CD: begin
                time_data_o = cd_q;
                running_o   = (cd_state_q == CD_RUN);
            end
            default: time_data_o = (lcnt_q == '0) ? 24'd0 : lap_buf_q[rd_q];
        endcase
    end

    assign lap_count_o = lcnt_q;
    assign alarm_o     = (cd_state_q == CD_ALARM);

endmodule

// File: tb/tb_multi_mode_timer.sv
module tb_multi_mode_timer;
    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int HOUR_MAX  = 24;
    localparam int LAP_DEPTH = 4;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int CW        = $clog2(LAP_DEPTH + 1);

    localparam int B_START = 0, B_CLEAR = 1, B_LAP = 2, B_UP = 3, B_DOWN = 4;
    localparam int S_TIME = 0, S_LCNT = 1, S_RUN = 2, S_ALARM = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [1:0]    set_sel = 2'b11;
    logic          btn_start = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
    logic          btn_up = 1'b0, btn_down = 1'b0;
    logic [23:0]   time_data;
    logic [CW-1:0] lap_count;
    logic          running, alarm;

    always #5 clk = ~clk;

    multi_mode_timer #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MAX(HOUR_MAX), .LAP_DEPTH(LAP_DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode),
        .btn_start_i(btn_start), .btn_clear_i(btn_clear), .btn_lap_i(btn_lap),
        .set_sel_i(set_sel), .btn_up_i(btn_up), .btn_down_i(btn_down),
        .time_data_o(time_data), .lap_count_o(lap_count),
        .running_o(running), .alarm_o(alarm)
    );

    // Reference tick: registered pulse while the divider sits on its last value.
    int   div_m;
    logic tick_m;
    always @(posedge clk) begin
        if (!rst) begin
            div_m  <= 0;
            tick_m <= 1'b0;
        end else begin
            tick_m <= (div_m == DIV - 1);
            div_m  <= (div_m == DIV - 1) ? 0 : div_m + 1;
        end
    end

    int n_run  = 0;
    int n_fail = 0;
    int tcount = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t        sb[$];
    logic [23:0] caps[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_TIME:  check(e.tag, {8'h00, time_data}, e.exp);
                S_LCNT:  check(e.tag, 32'(lap_count), e.exp);
                S_RUN:   check(e.tag, {31'd0, running}, e.exp);
                default: check(e.tag, {31'd0, alarm}, e.exp);
            endcase
        end
    endtask

    function automatic logic [23:0] pack(input int h, input int m, input int s, input int ms);
        return {h[4:0], m[5:0], s[5:0], ms[6:0]};
    endfunction

    function automatic logic [23:0] from_ticks(input int n);
        return pack((n / (TICK_HZ * 3600)) % HOUR_MAX, (n / (TICK_HZ * 60)) % 60,
                    (n / TICK_HZ) % 60, n % TICK_HZ);
    endfunction

    task automatic step();
        if (tick_m) tcount++;
        @(negedge clk);
    endtask

    task automatic press(input int b);
        case (b)
            B_START: btn_start = 1'b1;
            B_CLEAR: btn_clear = 1'b1;
            B_LAP:   btn_lap   = 1'b1;
            B_UP:    btn_up    = 1'b1;
            default: btn_down  = 1'b1;
        endcase
        step();
        btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            if (tick_m) k++;
            step();
        end
    endtask

    task automatic to_tick();
        while (!tick_m) step();
    endtask

    task automatic no_tick();
        while (tick_m) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        tcount = 0;
    endtask

    task automatic check_reset_state(input string tag);
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            expect_out({tag, "_time"}, S_TIME, 0);
            expect_out({tag, "_run"}, S_RUN, (m == 0) ? 1 : 0);
            expect_out({tag, "_alarm"}, S_ALARM, 0);
            expect_out({tag, "_lcnt"}, S_LCNT, 0);
            drain();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d tests run", n_run);
        $fatal(1);
    end

    initial begin
        int t0, k, tm, ms;
        int order[4];

        @(negedge clk);
        do_reset();
        check_reset_state("reset");

        // Stopwatch basic count and minute carry, clear ignored in RUN
        do_reset();
        mode = 2'b01;
        press(B_START);
        t0 = tcount;
        wait_ticks(10);
        expect_out("sw_10ticks", S_TIME, 24'h00000A);
        expect_out("sw_running", S_RUN, 1);
        drain();
        wait_ticks(5989);
        expect_out("sw_59_99", S_TIME, pack(0, 0, 59, 99));
        drain();
        wait_ticks(1);
        expect_out("sw_1min", S_TIME, pack(0, 1, 0, 0));
        drain();
        press(B_CLEAR);
        expect_out("sw_clear_in_run", S_TIME, from_ticks(tcount - t0));
        expect_out("sw_still_running", S_RUN, 1);
        drain();

        // Watch day wrap and manual adjust
        do_reset();
        mode = 2'b00;
        set_sel = 2'b10; no_tick(); press(B_DOWN);
        set_sel = 2'b01; no_tick(); press(B_DOWN);
        set_sel = 2'b00; no_tick(); press(B_DOWN);
        set_sel = 2'b11;
        k = tcount;
        expect_out("watch_set", S_TIME, pack(23, 59, 59, k));
        drain();
        wait_ticks(99 - k);
        expect_out("watch_23_59_59_99", S_TIME, pack(23, 59, 59, 99));
        drain();
        wait_ticks(1);
        expect_out("watch_day_wrap", S_TIME, 0);
        expect_out("watch_running", S_RUN, 1);
        drain();
        tm = tcount;
        set_sel = 2'b00;
        no_tick();
        press(B_DOWN);
        expect_out("watch_sec_down", S_TIME, pack(0, 0, 59, tcount - tm));
        drain();
        to_tick();
        ms = tcount - tm;
        press(B_UP);
        expect_out("watch_up_vs_tick", S_TIME, pack(0, 0, 0, ms));
        drain();
        set_sel = 2'b11;

        // Lap capture, overwrite of oldest, lap view stepping
        do_reset();
        mode = 2'b01;
        press(B_START);
        t0 = tcount;
        for (int i = 0; i < 5; i++) begin
            wait_ticks(3 + i * 4);
            if (i == 2) to_tick();
            caps.push_back(from_ticks(tcount - t0));
            press(B_LAP);
            expect_out("lap_count_step", S_LCNT, (i < LAP_DEPTH) ? i + 1 : LAP_DEPTH);
            drain();
        end
        mode = 2'b11;
        expect_out("lapview_first", S_TIME, caps[1]);
        expect_out("lapview_running", S_RUN, 0);
        drain();
        order = '{2, 3, 4, 1};
        for (int j = 0; j < 4; j++) begin
            press(B_LAP);
            expect_out("lapview_step", S_TIME, caps[order[j]]);
            expect_out("lapview_lcnt", S_LCNT, LAP_DEPTH);
            drain();
        end

        // Countdown with alarm
        do_reset();
        mode = 2'b10;
        set_sel = 2'b00;
        press(B_UP);
        press(B_UP);
        set_sel = 2'b11;
        expect_out("cd_preset", S_TIME, pack(0, 0, 2, 0));
        expect_out("cd_idle_run", S_RUN, 0);
        drain();
        press(B_START);
        expect_out("cd_running", S_RUN, 1);
        drain();
        wait_ticks(199);
        expect_out("cd_0_01", S_TIME, pack(0, 0, 0, 1));
        expect_out("cd_no_alarm_yet", S_ALARM, 0);
        drain();
        wait_ticks(1);
        expect_out("cd_zero", S_TIME, 0);
        expect_out("cd_alarm", S_ALARM, 1);
        expect_out("cd_alarm_run", S_RUN, 0);
        drain();
        repeat (5) step();
        expect_out("cd_alarm_hold", S_ALARM, 1);
        expect_out("cd_zero_hold", S_TIME, 0);
        drain();
        press(B_CLEAR);
        expect_out("cd_ack", S_ALARM, 0);
        expect_out("cd_reload", S_TIME, pack(0, 0, 2, 0));
        drain();
        mode = 2'b01;
        set_sel = 2'b00;
        press(B_UP);
        set_sel = 2'b11;
        mode = 2'b10;
        expect_out("cd_inactive_btn", S_TIME, pack(0, 0, 2, 0));
        drain();

        // Countdown start with zero preset is ignored
        do_reset();
        mode = 2'b10;
        press(B_START);
        expect_out("cd_zero_start_run", S_RUN, 0);
        expect_out("cd_zero_start_alarm", S_ALARM, 0);
        drain();
        wait_ticks(10);
        expect_out("cd_zero_stays", S_TIME, 0);
        expect_out("cd_zero_stays_run", S_RUN, 0);
        drain();

        // Reset mid-operation while each mode is displayed
        for (int m = 0; m < 4; m++) begin
            do_reset();
            mode = 2'b01;
            press(B_START);
            wait_ticks(5);
            press(B_LAP);
            mode = 2'b10;
            set_sel = 2'b00;
            press(B_UP);
            set_sel = 2'b11;
            press(B_START);
            wait_ticks(3 + m);
            mode = 2'(m);
            do_reset();
            check_reset_state("midrun_reset");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
